// File: rtl/dram_burst_reader.sv
// dram_burst_reader: read-side burst master for the 4-bit weight DRAM.
// Issues sequential reads and returns the words as a valid/ready stream
// with a last-beat marker. A 2-entry buffer with credit-gated issue
// absorbs the 1-cycle read latency under downstream backpressure.
module dram_burst_reader #(
  parameter int unsigned D_WIDTH = 4,
  parameter int unsigned A_WIDTH = 15,
  parameter int unsigned L_WIDTH = A_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [L_WIDTH-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic               mem_rce,
  output logic [A_WIDTH-1:0] mem_ra,
  input  logic [D_WIDTH-1:0] mem_rq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t                      r_state;
  logic [A_WIDTH-1:0]          r_addr;
  logic [L_WIDTH-1:0]          r_issue_left;
  logic [L_WIDTH-1:0]          r_beats_left;
  logic                        r_rv;      // a read issued last cycle returns on mem_rq now
  logic [1:0]                  r_cnt;     // words held in the buffer
  logic [1:0][D_WIDTH-1:0]     r_buf;     // entry 0 is the head

  logic [1:0]                  w_occ;
  logic                        w_issue;
  logic                        w_valid;
  logic                        w_pop;
  logic [D_WIDTH-1:0]          w_head;
  logic [1:0]                  w_cnt_n;
  logic [1:0][D_WIDTH-1:0]     w_buf_n;

  // Occupancy plus the word arriving this cycle; issue only while below 2.
  assign w_occ   = r_cnt + {1'b0, r_rv};
  assign w_issue = (r_state == ISSUE) && (w_occ < 2'd2);

  // Fall-through: an empty buffer presents the returning word directly, so
  // the first beat is visible in the cycle its read data arrives. If that
  // word is not taken it is stored and keeps being presented unchanged.
  assign w_valid = (r_cnt != 2'd0) || r_rv;
  assign w_pop   = w_valid && out_ready;
  assign w_head  = (r_cnt != 2'd0) ? r_buf[0] : mem_rq;

  assign out_valid = w_valid;
  assign out_data  = w_valid ? w_head : '0;
  assign out_last  = w_valid && (r_beats_left == L_WIDTH'(1));

  assign mem_rce = w_issue;
  assign mem_ra  = r_addr;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FIN);

  // Next buffer contents: pop a stored head first, then append the return
  // unless it was consumed straight through an empty buffer.
  always_comb begin
    w_buf_n = r_buf;
    w_cnt_n = r_cnt;
    if (w_pop && (r_cnt != 2'd0)) begin
      w_buf_n[0] = r_buf[1];
      w_cnt_n    = r_cnt - 2'd1;
    end
    if (r_rv && !(w_pop && (r_cnt == 2'd0))) begin
      w_buf_n[w_cnt_n[0]] = mem_rq;
      w_cnt_n             = w_cnt_n + 2'd1;
    end
  end

  // Buffer storage; reset discards held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else begin
      r_cnt <= w_cnt_n;
      r_buf <= w_buf_n;
    end
  end

  // Burst control FSM with address and issue/beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_beats_left <= '0;
      r_rv         <= 1'b0;
    end else begin
      r_rv <= w_issue;
      if (w_pop && (r_beats_left != '0)) begin
        r_beats_left <= r_beats_left - L_WIDTH'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr       <= base_addr;
            r_issue_left <= burst_len;
            r_beats_left <= burst_len;
            r_state      <= (burst_len == '0) ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_addr       <= r_addr + A_WIDTH'(1);
            r_issue_left <= r_issue_left - L_WIDTH'(1);
            if (r_issue_left == L_WIDTH'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && (r_beats_left == L_WIDTH'(1))) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A return landing in a full buffer would lose a word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(r_rv && (r_cnt == 2'd2) && !w_pop))
        else $error("dram_burst_reader: read return into full buffer");
    end
  end

endmodule

// File: doc/dram_burst_reader.md
Name: dram_burst_reader

Overview:
- Read-side master for the 4-bit-wide weight DRAM (`rce`/`ra`/`rq` port, 1-cycle registered read latency).
- Takes a burst command (base address, length) and issues sequential reads.
- Returns the data as a valid/ready stream with a last-beat marker, which feeds the layer-1 weight path to the compute array.
- A small internal buffer absorbs the read latency so downstream backpressure never drops or duplicates a word.

Parameters:
- D_WIDTH, 4, data word width; equals the DRAM data width.
- A_WIDTH, 15, DRAM address width; depth = 2^A_WIDTH.
- L_WIDTH, A_WIDTH+1, burst length width; allows a full-memory burst of 2^A_WIDTH words.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; accepted only in IDLE.
- base_addr  in  A_WIDTH  first DRAM address of the burst.
- burst_len  in  L_WIDTH  number of words to read; 0 is legal.
- busy  out  1  high from command acceptance until the cycle `done` pulses (inclusive).
- done  out  1  one-cycle pulse when the burst is complete.
- mem_rce  out  1  DRAM read enable.
- mem_ra  out  A_WIDTH  DRAM read address.
- mem_rq  in  D_WIDTH  DRAM read data; valid one cycle after `mem_rce`.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  D_WIDTH  stream data.
- out_last  out  1  high with the final beat of the burst.

Behaviour:
- Reset: every cycle `rst` is high the block goes to IDLE.
  - busy=0, done=0, mem_rce=0, mem_ra=0, out_valid=0, out_last=0, out_data=0.
  - Buffer is emptied, counters are cleared, any in-flight read is discarded.
  - `rst` overrides `start` in the same cycle.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - On `start`=1, latch base_addr and burst_len.
  - If burst_len==0, go to FIN. No reads issued, no beats produced.
  - Otherwise go to ISSUE; busy=1 from the next cycle.
- ISSUE:
  - Assert mem_rce=1 with mem_ra=current address only when (buffer occupancy + reads in flight) < 2.
  - Each issue increments the address modulo 2^A_WIDTH (0x7FFF wraps to 0x0000) and decrements the remaining-issue count.
  - After the last read is issued, go to DRAIN.
- DRAIN:
  - Wait until all returned words have been accepted downstream (buffer empty, none in flight), then go to FIN.
- FIN: done=1 for exactly one cycle, busy still 1; next cycle go to IDLE with busy=0.
- Read return:
  - The word on mem_rq in the cycle after mem_rce=1 is written into a 2-entry FIFO.
  - mem_rq is ignored in all other cycles.
- Output stream:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A beat transfers when out_valid && out_ready.
  - Once out_valid is asserted, out_data and out_last hold stable until the transfer.
  - out_last is high exactly on the burst_len-th beat.
- Throughput: with out_ready held at 1, one beat per cycle.
  - First out_valid appears 2 cycles after the `start` cycle.
  - done pulses 1 cycle after the last beat transfers.
- Simultaneous FIFO push and pop in the same cycle is legal; occupancy is unchanged.
- The credit rule guarantees the FIFO never overflows. A push into a full FIFO is a design error; flag it with an assertion.
- `start` while busy is ignored; the latched command is unaffected.
- The block never drives the DRAM write port.

Test Plan:
- DRAM preloaded mem[0x0010..0x0013]={3,7,A,F}; start base=0x0010 len=4, out_ready=1.
  - Expect mem_ra 0x10..0x13 on 4 consecutive cycles and beats 3,7,A,F on consecutive cycles.
  - Expect out_last on F and a done pulse one cycle later.
- Same burst with out_ready toggling 1,0,0,1,0,1...
  - Expect beats still exactly 3,7,A,F in order, data stable while stalled.
  - Expect mem_rce never asserted when buffer+in-flight=2, and no lost or duplicated beats.
- Wrap: mem[0x7FFE]=1, mem[0x7FFF]=2, mem[0x0000]=5; base=0x7FFE len=3.
  - Expect addresses 0x7FFE, 0x7FFF, 0x0000 and beats 1,2,5, with out_last on 5.
- len=0 start: expect no mem_rce and no out_valid; busy=1 and done=1 in the single FIN cycle after start, then IDLE.
- Reset mid-burst: base=0 len=8, rst=1 for one cycle after the 3rd beat.
  - Expect all outputs at reset values the next cycle, with no further beats or done.
  - A new start base=0x0100 len=2 then completes normally.
- start pulsed again mid-burst with base=0x0200: expect it ignored and the original burst to complete with the original addresses.
